// File: rtl/wt_dcache_pkg.sv
// Shared types and width helpers for the write-through data cache.
// Used by wt_dcache and dcache_line_array.
package wt_dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

  // Top three address bits selecting the uncached KSEG1 window.
  localparam logic [2:0] KSEG1_SEG = 3'b101;

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int line_count(input int index_w);
    return 1 << index_w;
  endfunction

  function automatic int tag_bits(input int addr_w, input int data_w, input int index_w);
    return addr_w - index_w - off_bits(data_w);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for wt_dcache: valid flops with async clear, tag and byte-lane data
// arrays with a combinational read port and one byte-strobed write port.
module dcache_line_array
  import wt_dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int LINES = line_count(INDEX_BITS);
  localparam int NB    = DATA_W / 8;

  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (wr_en && wr_fill) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  // Tag only changes on a fill; write hits merge data under the existing tag.
  always_ff @(posedge clk) begin
    if (wr_en && wr_fill) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [LINES];

      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) begin
          lane_mem[wr_index] <= wr_data[gi*8 +: 8];
        end
      end

      assign rd_data[gi*8 +: 8] = lane_mem[rd_index];
    end
  endgenerate

endmodule

// File: rtl/wt_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional macro UNCACHED_KSEG1_EN makes the KSEG1 window (top bits 3'b101) uncached.
module wt_dcache
  import wt_dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int OFF   = off_bits(DATA_W);
  localparam int TAG_W = tag_bits(ADDR_W, DATA_W, INDEX_BITS);
  localparam int NB    = DATA_W / 8;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [NB-1:0]     wstrb_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              uncached_reg;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  is_write;
  logic                  uncached;
  logic                  hit;
  logic                  start;
  logic                  load_hit;
  logic                  load_fill;
  logic                  unused_off;

  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_W-1:0]     line_data;

  logic                  arr_wr_en;
  logic                  arr_wr_fill;
  logic [INDEX_BITS-1:0] arr_wr_index;
  logic [TAG_W-1:0]      arr_wr_tag;
  logic [NB-1:0]         arr_wr_be;
  logic [DATA_W-1:0]     arr_wr_data;

  assign req_index  = data_addr[OFF +: INDEX_BITS];
  assign req_tag    = data_addr[ADDR_W-1 -: TAG_W];
  assign is_write   = |data_wen;
  assign unused_off = ^data_addr[OFF-1:0];

`ifdef UNCACHED_KSEG1_EN
  assign uncached = (data_addr[ADDR_W-1 -: 3] == KSEG1_SEG);
`else
  assign uncached = 1'b0;
`endif

  assign hit = !uncached && line_valid && (line_tag == req_tag);

  dcache_line_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W),
    .DATA_W    (DATA_W)
  ) u_lines (
    .clk     (clk),
    .rst     (rst),
    .rd_index(req_index),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (arr_wr_en),
    .wr_fill (arr_wr_fill),
    .wr_index(arr_wr_index),
    .wr_tag  (arr_wr_tag),
    .wr_be   (arr_wr_be),
    .wr_data (arr_wr_data)
  );

  // Write port: store hits merge the CPU bytes; refills take the whole bus word.
  always_comb begin
    arr_wr_en    = 1'b0;
    arr_wr_fill  = 1'b0;
    arr_wr_index = req_index;
    arr_wr_tag   = req_tag;
    arr_wr_be    = data_wen;
    arr_wr_data  = data_wdata;
    if (state_reg == IDLE && data_en && is_write && hit) begin
      arr_wr_en = 1'b1;
    end else if (state_reg == RD_WAIT && mem_data_ok && !uncached_reg) begin
      arr_wr_en    = 1'b1;
      arr_wr_fill  = 1'b1;
      arr_wr_index = addr_reg[OFF +: INDEX_BITS];
      arr_wr_tag   = addr_reg[ADDR_W-1 -: TAG_W];
      arr_wr_be    = '1;
      arr_wr_data  = mem_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    start      = 1'b0;
    load_hit   = 1'b0;
    load_fill  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (data_en) begin
          if (is_write) begin
            stall      = 1'b1;
            start      = 1'b1;
            state_next = WR_REQ;
          end else if (!hit) begin
            stall      = 1'b1;
            start      = 1'b1;
            state_next = RD_REQ;
          end else begin
            load_hit = 1'b1;
          end
        end
      end
      // A data_ok coinciding with addr_ok belongs to no accepted request yet.
      RD_REQ: begin
        stall = 1'b1;
        if (mem_addr_ok) state_next = RD_WAIT;
      end
      WR_REQ: begin
        stall = 1'b1;
        if (mem_addr_ok) state_next = WR_WAIT;
      end
      RD_WAIT: begin
        stall = !mem_data_ok;
        if (mem_data_ok) begin
          load_fill  = 1'b1;
          state_next = IDLE;
        end
      end
      WR_WAIT: begin
        stall = !mem_data_ok;
        if (mem_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      rdata_reg    <= '0;
      uncached_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        addr_reg     <= {data_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
        wdata_reg    <= data_wdata;
        wstrb_reg    <= data_wen;
        uncached_reg <= uncached;
      end
      if (load_hit) begin
        rdata_reg <= line_data;
      end else if (load_fill) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign mem_req    = (state_reg == RD_REQ) || (state_reg == WR_REQ);
  assign mem_wr     = (state_reg == WR_REQ);
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_wstrb  = wstrb_reg;
  assign data_rdata = rdata_reg;

endmodule

// File: tb/tb_wt_dcache.sv
// Scoreboard bench for wt_dcache: a bus responder with backing memory, a reference
// hit/miss model and a queue of expected load data popped when each load completes.
module tb_wt_dcache;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IB = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_en = 1'b0;
  logic [3:0]    data_wen = '0;
  logic [31:0]   data_addr = '0;
  logic [31:0]   data_wdata = '0;
  logic [31:0]   data_rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_wr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_addr_ok;
  logic          mem_data_ok;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  wt_dcache #(.ADDR_W(AW), .DATA_W(DW), .INDEX_BITS(IB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_en    (data_en),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          bus_rd_cnt = 0;
  int          bus_wr_cnt = 0;
  bit          pending = 0;
  bit          slow = 0;
  bit          glitch = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  logic        last_wr = 1'b0;

  bit          ref_valid [64];
  logic [23:0] ref_tag [64];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q [$];

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : def_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
  endfunction

  function automatic bit is_unc(input logic [31:0] a);
`ifdef UNCACHED_KSEG1_EN
    return a[31:29] == 3'b101;
`else
    return a[31] & 1'b0;
`endif
  endfunction

  // Bus responder: random accept and data latencies, one outstanding transfer.
  initial begin
    int dly;
    int acc_wait;
    logic [31:0] cur;
    dly = 0;
    acc_wait = 0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata = '0;
      if (rst) begin
        pending = 0;
        acc_wait = 0;
      end else if (pending) begin
        if (dly > 0) begin
          dly--;
        end else begin
          mem_data_ok = 1'b1;
          if (!last_wr) begin
            mem_rdata = bus_rd(last_addr);
          end else begin
            cur = bus_rd(last_addr);
            for (int b = 0; b < 4; b++)
              if (last_wstrb[b]) cur[b*8 +: 8] = last_wdata[b*8 +: 8];
            bus_mem[last_addr] = cur;
          end
          pending = 0;
        end
      end else if (mem_req) begin
        if (acc_wait > 0) begin
          acc_wait--;
        end else begin
          mem_addr_ok = 1'b1;
          last_addr = mem_addr;
          last_wr = mem_wr;
          last_wstrb = mem_wstrb;
          last_wdata = mem_wdata;
          if (mem_wr) bus_wr_cnt++;
          else bus_rd_cnt++;
          pending = 1;
          dly = slow ? 12 : int'($urandom_range(0, 2));
          acc_wait = int'($urandom_range(0, 2));
          if (glitch) begin
            mem_data_ok = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
            glitch = 0;
          end
        end
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    logic [31:0] wa;
    logic [31:0] cur;
    logic [23:0] tg;
    int idx;
    bit unc, hit, wr;
    int rd0, wr0, c;
    exp_t e;
    wa  = {addr[31:2], 2'b00};
    idx = int'(addr[7:2]);
    tg  = addr[31:8];
    unc = is_unc(addr);
    wr  = |wen;
    hit = !unc && ref_valid[idx] && (ref_tag[idx] == tg);
    if (wr) begin
      cur = ref_rd(wa);
      for (int b = 0; b < 4; b++)
        if (wen[b]) cur[b*8 +: 8] = wdata[b*8 +: 8];
      ref_mem[wa] = cur;
    end else begin
      e.addr = wa;
      e.data = ref_rd(wa);
      exp_q.push_back(e);
      if (!hit && !unc) begin
        ref_valid[idx] = 1;
        ref_tag[idx] = tg;
      end
    end
    rd0 = bus_rd_cnt;
    wr0 = bus_wr_cnt;
    @(negedge clk);
    data_en = 1'b1;
    data_wen = wen;
    data_addr = addr;
    data_wdata = wdata;
    #1;
    check("stall_first", {31'd0, stall}, {31'd0, (wr || !hit)});
    c = 0;
    while (stall && c < 60) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("complete", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    if (!wr) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", data_rdata, e.data);
      end
    end
    check("bus_rd", bus_rd_cnt - rd0, (!wr && !hit) ? 32'd1 : 32'd0);
    check("bus_wr", bus_wr_cnt - wr0, wr ? 32'd1 : 32'd0);
    if (wr || !hit) begin
      check("mem_addr", last_addr, wa);
      check("mem_wr", {31'd0, last_wr}, {31'd0, wr});
      if (wr) begin
        check("mem_wstrb", {28'd0, last_wstrb}, {28'd0, wen});
        check("mem_wdata", last_wdata, wdata);
      end
    end
    $display("txn %s addr=%h wen=%b wdata=%h rdata=%h hit=%0d", wr ? "WR" : "RD", addr, wen,
             wdata, data_rdata, hit);
    data_en = 1'b0;
    data_wen = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr_set [8];
    int found;
    for (int i = 0; i < 64; i++) begin
      ref_valid[i] = 0;
      ref_tag[i] = '0;
    end
    addr_set[0] = 32'h0000_0000; addr_set[1] = 32'h0000_0004;
    addr_set[2] = 32'h0000_0100; addr_set[3] = 32'h0000_0104;
    addr_set[4] = 32'h0000_0200; addr_set[5] = 32'h0000_0208;
    addr_set[6] = 32'h0000_1000; addr_set[7] = 32'hA000_0004;
    bus_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    #2 rst = 1'b0;

    access(32'h0000_0100, 4'b0000, 32'h0);
    access(32'h0000_0100, 4'b0000, 32'h0);
    access(32'h0000_0100, 4'b0011, 32'h0000_1234);
    access(32'h0000_0100, 4'b0000, 32'h0);
    access(32'h0000_0200, 4'b1111, 32'hCAFE_F00D);
    access(32'h0000_0200, 4'b0000, 32'h0);
    access(32'h0000_0100, 4'b0000, 32'h0);
    access(32'h0000_0100 + (32'd1 << (IB + 2)), 4'b0000, 32'h0);
    access(32'h0000_0100, 4'b0000, 32'h0);

    glitch = 1;
    access(32'h0000_0304, 4'b0000, 32'h0);
    access(32'h0000_0304, 4'b0000, 32'h0);

    access(32'hA000_0000, 4'b0000, 32'h0);
    access(32'hA000_0000, 4'b0000, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      access(addr_set[$urandom_range(0, 7)], w, $urandom);
    end

    // Abort a read while it waits for bus data.
    access(32'h0000_0100, 4'b0000, 32'h0);
    slow = 1;
    @(negedge clk);
    data_en = 1'b1;
    data_wen = 4'b0000;
    data_addr = 32'h0000_0404;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      #1;
      if (pending && !mem_req) found = 1;
    end
    check("rdwait_reached", found, 32'd1);
    #2;
    rst = 1'b1;
    data_en = 1'b0;
    #1;
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_rdata", data_rdata, 32'd0);
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    slow = 0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    access(32'h0000_0100, 4'b0000, 32'h0);
    access(32'h0000_0100, 4'b0000, 32'h0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wt_dcache.md
Name: wt_dcache

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache.
- Sits between the datapath memory-stage port and an sram-like bus with address and data handshakes.
- Replaces the current pass-through data cache: adds real lookup, a miss/write FSM and a CPU stall output.
- One-word lines; the datapath holds its request stable while stall is high.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, word width in bits; must be a power of two and at least 8.
- INDEX_BITS, 6, log2 of the number of lines (default 64 lines).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- data_en  in  1  CPU access request.
- data_wen  in  DATA_W/8  byte write strobes; any bit set marks a write, zero marks a read.
- data_addr  in  ADDR_W  byte address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load data, registered.
- stall  out  1  CPU must hold its request and freeze.
- mem_req  out  1  bus request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_wstrb  out  DATA_W/8  byte strobes.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_wdata  out  DATA_W  write data.
- mem_addr_ok  in  1  bus accepted the request.
- mem_data_ok  in  1  bus returned read data or write completion.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Address split:
  - OFF = log2(DATA_W/8) low bits, ignored.
  - Index = next INDEX_BITS bits.
  - Tag = remaining ADDR_W-INDEX_BITS-OFF bits.
  - hit = valid[index] && tag match, evaluated combinationally.
- Reset (async):
  - All valid bits = 0, state = IDLE.
  - mem_req = 0, mem_wr = 0, data_rdata = 0, stall = 0, mem_addr/mem_wdata/mem_wstrb = 0.
  - Tag and data arrays are not reset.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE:
  - No data_en: nothing happens; stall = 0.
  - Read hit: data_rdata <= line data at the clock edge (1-cycle latency); stall = 0.
  - Read miss: stall = 1 combinationally; latch the word address; go to RD_REQ.
  - Write hit: merge bytes per data_wen into the line in this cycle; latch address/data/strobes; go to WR_REQ; stall = 1.
  - Write miss: array untouched (no allocate); same latch and transition as a write hit.
- RD_REQ / WR_REQ:
  - mem_req = 1 and mem_wr set for the access type; outputs held stable until mem_addr_ok.
  - On mem_addr_ok: mem_req drops next cycle; go to RD_WAIT / WR_WAIT.
- RD_WAIT:
  - On mem_data_ok: write tag, data and valid = 1 for the line; data_rdata <= mem_rdata; go to IDLE.
- WR_WAIT:
  - On mem_data_ok: go to IDLE.
- stall:
  - In IDLE: data_en && (miss || write).
  - In non-IDLE states: 1, except 0 in the mem_data_ok cycle of a *_WAIT state, so the CPU advances on that edge.
  - A held read therefore completes exactly once; a write is never re-issued.
- Boundaries:
  - mem_addr_ok and mem_data_ok in the same cycle while in *_REQ: accepted as addr_ok only; data_ok is expected later.
  - Only one outstanding bus transaction at a time.
  - A read after a write to the same word hits with the merged data.
  - Index wrap: addresses differing only in tag evict each other (read fill overwrites).
  - rst mid-transaction: immediate return to IDLE with all lines invalid. The bus side shares rst, so the abandoned transaction is dropped.

Optional Feature:
- Macro: UNCACHED_KSEG1_EN.
- Defined:
  - Addresses with data_addr[ADDR_W-1:ADDR_W-3] == 3'b101 are uncached.
  - Uncached reads always take the RD_REQ path with no lookup and no fill.
  - Uncached writes never touch the arrays.
- Undefined: all addresses are cached.

Decomposition:
- Package wt_dcache_pkg holds:
  - The state enum.
  - The KSEG1 segment constant 3'b101.
  - Width helper functions: offset, index and tag bit counts derived from the parameters.
- One natural sub-module, dcache_line_array:
  - Valid flops (async clear), tag and data storage.
  - Combinational read port, one write port with byte strobes.

Test Plan:
- Reset, then read 0x0000_0100 → stall=1 and mem_req with mem_addr=0x100. After addr_ok, data_ok with rdata=0xDEADBEEF → stall low that cycle, data_rdata=0xDEADBEEF next cycle. A repeat read hits with no mem_req.
- Write 0x100 with wen=4'b0011, wdata=0x0000_1234 → mem_req, mem_wr=1, mem_wstrb=4'b0011. After data_ok, a read of 0x100 hits and returns 0xDEAD1234.
- Write miss at 0x200 → bus write issued; a subsequent read of 0x200 misses (no allocate).
- Conflict: read 0x100, then read 0x100+(1<<(INDEX_BITS+2)) → second misses and refills. A re-read of 0x100 misses again.
- Assert rst while in RD_WAIT → state IDLE, mem_req=0, stall=0. A read of a previously cached address misses.
- With UNCACHED_KSEG1_EN: two reads of 0xA000_0000 → two bus reads, no hit. Without the macro → the second read hits.
